// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake between the MMIO register block and the UART TX FIFO.
// The master offers a byte with i_Tx_DV. The slave accepts it in any cycle
// where o_Tx_Ready is high.
interface uart_tx_fifo_if;
   logic       i_Tx_DV;
   logic [7:0] i_Tx_Byte;
   logic       o_Tx_Ready;

   modport master (output i_Tx_DV, output i_Tx_Byte, input  o_Tx_Ready);
   modport slave  (input  i_Tx_DV, input  i_Tx_Byte, output o_Tx_Ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small input FIFO.
// - Bytes are queued through the write handshake interface.
// - Each byte is popped when the FSM is idle and then shifted out LSB-first.
// - o_Tx_Serial and o_Tx_Active are registered, so they trail the FSM state by one cycle.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT    = 100,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic                     i_Clock,
   input  logic                     i_Reset,
   uart_tx_fifo_if.slave            tx_if,
   output logic                     o_Tx_Serial,
   output logic                     o_Tx_Active,
   output logic                     o_Tx_Done,
   output logic [FIFO_DEPTH_LOG2:0] o_Fifo_Count
);
   localparam int                 DEPTH    = 1 << FIFO_DEPTH_LOG2;
   localparam int                 CNT_W    = FIFO_DEPTH_LOG2 + 1;
   localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);
   localparam logic [7:0]         CLK_LAST = 8'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      CLEANUP = 3'd4
   } state_t;

   logic [7:0]                 mem_q [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]           count_q, count_d;
   logic                       push, pop, ready;

   state_t     state_q, state_d;
   logic [7:0] clk_cnt_q, clk_cnt_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shift_q, shift_d;
   logic       done_q, done_d;
   logic       serial_q, serial_d;
   logic       active_q, active_d;

   // The head is popped only from IDLE. While a pop is happening, the slot it
   // frees is offered to the writer in the same cycle. This lets a full FIFO
   // accept a byte at a frame boundary without a bubble. The bypass uses only
   // registered state, so there is no combinational path from i_Tx_DV.
   assign pop     = (state_q == IDLE) && (count_q != '0);
   assign ready   = (count_q != CNT_FULL) || pop;
   assign push    = tx_if.i_Tx_DV && ready;
   assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

   assign tx_if.o_Tx_Ready = ready;
   assign o_Fifo_Count     = count_q;
   assign o_Tx_Serial      = serial_q;
   assign o_Tx_Active      = active_q;
   assign o_Tx_Done        = done_q;

   // FIFO pointers and occupancy (pointers wrap naturally at the depth)
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_LOG2'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_LOG2'(1);
         count_q <= count_d;
      end
   end

   // FIFO storage: the byte is captured at push time; no reset is needed on the data
   always_ff @(posedge i_Clock) begin
      if (push) mem_q[wr_ptr_q] <= tx_if.i_Tx_Byte;
   end

   // FSM state and control counters
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         done_q    <= done_d;
      end
   end

   // Shift register holding the frame currently on the line
   always_ff @(posedge i_Clock) begin
      shift_q <= shift_d;
   end

   // Next-state logic: bit timing, bit sequencing and the done pulse
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pop) begin
               shift_d   = mem_q[rd_ptr_q];
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = START;
            end
         end
         START: begin
            if (clk_cnt_q != CLK_LAST) begin
               clk_cnt_d = clk_cnt_q + 8'd1;
            end else begin
               clk_cnt_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (clk_cnt_q != CLK_LAST) begin
               clk_cnt_d = clk_cnt_q + 8'd1;
            end else begin
               clk_cnt_d = '0;
               if (bit_idx_q != 3'd7) begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end else begin
                  bit_idx_d = '0;
                  state_d   = STOP;
               end
            end
         end
         STOP: begin
            if (clk_cnt_q != CLK_LAST) begin
               clk_cnt_d = clk_cnt_q + 8'd1;
            end else begin
               clk_cnt_d = '0;
               done_d    = 1'b1;
               state_d   = CLEANUP;
            end
         end
         CLEANUP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode of the current state, registered below
   always_comb begin
      serial_d = 1'b1;
      active_d = 1'b0;
      case (state_q)
         START: begin
            serial_d = 1'b0;
            active_d = 1'b1;
         end
         DATA: begin
            serial_d = shift_q[bit_idx_q];
            active_d = 1'b1;
         end
         STOP:    active_d = 1'b1;
         default: ;
      endcase
   end

   // Registered line outputs: the line goes high in the cycle after reset
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         serial_q <= 1'b1;
         active_q <= 1'b0;
      end else begin
         serial_q <= serial_d;
         active_q <= active_d;
      end
   end
endmodule
